sd_sector_loader: RTL and testbench
===================================

Name: sd_sector_loader

Overview:
- Parametrised successor to the hard-wired metadata fetch loop that feeds the SD controller.
- Streams a run-time-selected range of 512-byte SD sectors from the SPI sd_controller.
- Packs the bytes big-endian into BYTES_PER_WORD-byte words and emits them as a write stream with incrementing word address, for the metadata memory or song buffer.
- Adds abort, a ready timeout and a load-complete/error status that the game FSM uses in place of a fixed data_loaded flag.

Parameters:
BYTES_PER_WORD, 4, bytes packed per output word; legal values 1, 2, 4, 8.
ADDR_W, 12, width of the output word address.
SECT_W, 16, width of sector index and sector count.
TIMEOUT, 2500000, cycles to wait for sd_ready before flagging an error (100 ms at 25 MHz).

Ports:
clk  in  1  25 MHz clock shared with sd_controller
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; latches start_sector and sector_count; ignored unless in IDLE
abort  in  1  one-cycle pulse; cancels the load
start_sector  in  SECT_W  first sector index (byte address = index*512)
sector_count  in  SECT_W  number of sectors to load
sd_ready  in  1  sd_controller ready
sd_byte_available  in  1  sd_controller byte strobe (level)
sd_dout  in  8  sd_controller read byte
sd_rd  out  1  read request to sd_controller
sd_address  out  32  byte address to sd_controller
wr_en  out  1  one-cycle word write strobe
wr_addr  out  ADDR_W  word address
wr_data  out  8*BYTES_PER_WORD  packed word; first byte received in the MSBs
busy  out  1  high outside IDLE
done  out  1  sticky; set on successful completion, cleared by the next start
error  out  1  sticky; set on timeout, cleared by the next start

Behaviour:
- Reset values: sd_rd=0, sd_address=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, error=0. State=IDLE. All counters 0.
- States: IDLE, WAIT_READY, ISSUE, RECEIVE, DRAIN.
- IDLE:
  - start with sector_count=0 -> done=1 on the next cycle; state stays IDLE; no read issued.
  - start with sector_count>0 -> latch both inputs; clear done/error, sector_idx and wr_addr; go to WAIT_READY.
- WAIT_READY:
  - sd_address = (start_sector+sector_idx)<<9, computed in 32 bits.
  - Timeout counter increments each cycle.
  - sd_ready=1 -> ISSUE and counter resets.
  - Counter reaches TIMEOUT-1 -> error=1, go to IDLE.
- ISSUE:
  - sd_rd=1, held until sd_ready samples 0 (controller accepted), then sd_rd=0 and go to RECEIVE.
  - The same TIMEOUT applies.
- RECEIVE:
  - A byte is taken on each rising edge of sd_byte_available (registered edge detect), not on the level.
  - Byte k of the word lands in wr_data bits [8*(BPW-k)-1 -: 8].
  - On the last byte of a word: wr_en pulses for exactly one cycle, the cycle after the capturing edge; wr_addr holds that word's address during the pulse; wr_addr increments by 1 afterwards, wrapping modulo 2^ADDR_W.
  - Byte counter 0..511. After byte 511: sector_idx+1. If sector_idx+1 = sector_count -> done=1 and go to IDLE; else go to WAIT_READY.
  - Words never straddle sectors (BPW divides 512).
- abort in WAIT_READY -> IDLE immediately, done=0, no writes.
- abort in ISSUE or RECEIVE -> DRAIN: sd_rd=0, remaining bytes ignored, no wr_en; leave DRAIN to IDLE when sd_ready=1 or on timeout. done and error both remain 0.
- abort has priority over a simultaneous byte edge or a simultaneous start.
- A partially packed word is discarded on abort or error.
- Reset mid-operation returns to the reset values immediately, whatever the state.
- Latency: the first wr_en follows the BPW-th byte edge by one cycle.
- Words per load = sector_count*512/BYTES_PER_WORD.

Test Plan:
- start_sector=0x10, sector_count=2, BPW=4, model sends bytes 0x00..0xFF repeating -> sd_address 0x2000 then 0x2200; 256 wr_en pulses; wr_addr 0..255; word0=0x00010203; done=1, busy=0.
- BPW=1, sector_count=1, byte_available held high for 3 cycles per byte -> exactly 512 writes, one per byte, with no duplicates.
- sd_ready held low, TIMEOUT=1000 -> error=1 and state IDLE after 1000 cycles; sd_rd never asserted; a subsequent start clears error.
- abort after 100 bytes of sector 0 -> no further wr_en; DRAIN until sd_ready=1, then IDLE with done=0 and error=0; a new start with sector_count=1 completes normally.
- start with sector_count=0 -> done=1 next cycle, busy never high, no sd_rd.
- ADDR_W=4, sector_count=1, BPW=8 -> 64 writes; wr_addr wraps 15->0 four times; reset asserted mid-sector -> all outputs return to 0 asynchronously.

Source files
------------

// File: rtl/sd_sector_loader.sv
// sd_sector_loader
//   Streams a run-time-selected range of 512-byte sectors from the SPI
//   sd_controller and packs the bytes big-endian into BYTES_PER_WORD-byte
//   words. Each word is emitted as a one-cycle write strobe with an
//   incrementing word address. Supports abort, a ready timeout, and sticky
//   done/error status.
//
// Ports
//   clk, reset          : clock and asynchronous active-high reset
//   start, abort        : one-cycle command pulses (abort has priority)
//   start_sector        : first sector index (byte address = index*512)
//   sector_count        : number of sectors to load (0 -> immediate done)
//   sd_ready            : sd_controller idle/ready
//   sd_byte_available   : sd_controller byte strobe (level; rising edge used)
//   sd_dout             : sd_controller read byte
//   sd_rd, sd_address   : read request and byte address to sd_controller
//   wr_en, wr_addr,
//   wr_data             : word write stream (first byte in the MSBs)
//   busy                : high whenever the loader is not IDLE
//   done, error         : sticky status, cleared by the next accepted start
module sd_sector_loader #(
    parameter int BYTES_PER_WORD = 4,
    parameter int ADDR_W         = 12,
    parameter int SECT_W         = 16,
    parameter int TIMEOUT        = 2500000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        abort,
    input  logic [SECT_W-1:0]           start_sector,
    input  logic [SECT_W-1:0]           sector_count,
    input  logic                        sd_ready,
    input  logic                        sd_byte_available,
    input  logic [7:0]                  sd_dout,
    output logic                        sd_rd,
    output logic [31:0]                 sd_address,
    output logic                        wr_en,
    output logic [ADDR_W-1:0]           wr_addr,
    output logic [8*BYTES_PER_WORD-1:0] wr_data,
    output logic                        busy,
    output logic                        done,
    output logic                        error
);

    localparam int              WORD_W    = 8 * BYTES_PER_WORD;
    localparam int              TO_W      = $clog2(TIMEOUT + 1);
    localparam logic [8:0]      LANE_MASK = 9'(BYTES_PER_WORD - 1);
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_READY,
        ISSUE,
        RECEIVE,
        DRAIN
    } state_t;

    state_t state_q, state_d;

    logic [SECT_W-1:0] start_lat;
    logic [SECT_W-1:0] count_lat;
    logic [SECT_W-1:0] sector_idx;
    logic [8:0]        byte_cnt;
    logic [8:0]        lane;
    logic [TO_W-1:0]   to_cnt;
    logic              byte_av_p0;
    logic [WORD_W-1:0] pack;
    logic [WORD_W-1:0] word_next;
    logic              wr_en_p1;
    logic [WORD_W-1:0] wr_data_p1;
    logic [ADDR_W-1:0] wr_addr_q;
    logic              done_q;
    logic              error_q;

    logic byte_edge;
    logic to_hit;
    logic sector_last;
    logic load_last;
    logic word_last;

    logic start_load;
    logic clear_status;
    logic capture;
    logic set_done;
    logic set_error;

    // Bytes are taken on the rising edge of the level strobe so a byte held
    // for several cycles is only counted once.
    assign byte_edge   = sd_byte_available & ~byte_av_p0;
    assign to_hit      = (to_cnt == TO_LAST);
    assign sector_last = (byte_cnt == 9'd511);
    assign load_last   = ((sector_idx + SECT_W'(1)) == count_lat);
    assign lane        = byte_cnt & LANE_MASK;
    assign word_last   = capture && (lane == LANE_MASK);

    // Byte k of a word lands in the k-th most significant lane.
    always_comb begin
        word_next = pack;
        for (int k = 0; k < BYTES_PER_WORD; k++) begin
            if (lane == 9'(k)) begin
                word_next[8*(BYTES_PER_WORD-1-k) +: 8] = sd_dout;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        start_load   = 1'b0;
        clear_status = 1'b0;
        capture      = 1'b0;
        set_done     = 1'b0;
        set_error    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    clear_status = 1'b1;
                    if (sector_count == '0) begin
                        set_done = 1'b1;
                    end else begin
                        start_load = 1'b1;
                        state_d    = WAIT_READY;
                    end
                end
            end
            WAIT_READY: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (sd_ready) begin
                    state_d = ISSUE;
                end else if (to_hit) begin
                    set_error = 1'b1;
                    state_d   = IDLE;
                end
            end
            ISSUE: begin
                // sd_ready dropping means the controller accepted the read.
                if (abort) begin
                    state_d = DRAIN;
                end else if (!sd_ready) begin
                    state_d = RECEIVE;
                end else if (to_hit) begin
                    set_error = 1'b1;
                    state_d   = IDLE;
                end
            end
            RECEIVE: begin
                if (abort) begin
                    state_d = DRAIN;
                end else if (byte_edge) begin
                    capture = 1'b1;
                    if (sector_last) begin
                        set_done = load_last;
                        state_d  = load_last ? IDLE : WAIT_READY;
                    end
                end
            end
            DRAIN: begin
                // Let the controller finish its sector before going idle so
                // the next load starts from a clean controller state.
                if (sd_ready || to_hit) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_lat  <= '0;
            count_lat  <= '0;
            sector_idx <= '0;
            byte_cnt   <= '0;
            to_cnt     <= '0;
            byte_av_p0 <= 1'b0;
            pack       <= '0;
            wr_en_p1   <= 1'b0;
            wr_data_p1 <= '0;
            wr_addr_q  <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            // ---- stage p0: edge detect and byte capture ----
            byte_av_p0 <= sd_byte_available;

            if (state_d != state_q || state_q == IDLE || state_q == RECEIVE) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + TO_W'(1);
            end

            if (state_q != RECEIVE) begin
                byte_cnt <= '0;
            end else if (capture) begin
                byte_cnt <= byte_cnt + 9'd1;
            end

            if (capture) begin
                pack <= word_next;
            end

            if (capture && sector_last) begin
                sector_idx <= sector_idx + SECT_W'(1);
            end

            // ---- stage p1: word write strobe ----
            wr_en_p1 <= word_last;
            if (word_last) begin
                wr_data_p1 <= word_next;
            end

            // The address advances after the strobe so it is stable during it.
            if (wr_en_p1) begin
                wr_addr_q <= wr_addr_q + ADDR_W'(1);
            end

            if (start_load) begin
                start_lat  <= start_sector;
                count_lat  <= sector_count;
                sector_idx <= '0;
                wr_addr_q  <= '0;
            end

            if (clear_status) begin
                done_q  <= 1'b0;
                error_q <= 1'b0;
            end
            if (set_done) begin
                done_q <= 1'b1;
            end
            if (set_error) begin
                error_q <= 1'b1;
            end
        end
    end

    assign sd_address = (32'(start_lat) + 32'(sector_idx)) << 9;
    assign sd_rd      = (state_q == ISSUE);
    assign busy       = (state_q != IDLE);
    assign wr_en      = wr_en_p1;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_p1;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_sd_sector_loader.sv
module tb_sd_sector_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_a, start_b, start_c;
    logic        abort;
    logic [15:0] start_sector, sector_count;
    logic        sd_ready, avail;
    logic [7:0]  dout;

    logic        rd_a, rd_b, rd_c;
    logic [31:0] addr_a, addr_b, addr_c;
    logic        wr_en_a, wr_en_b, wr_en_c;
    logic [11:0] wr_addr_a, wr_addr_b;
    logic [3:0]  wr_addr_c;
    logic [31:0] wr_data_a;
    logic [7:0]  wr_data_b;
    logic [63:0] wr_data_c;
    logic        busy_a, busy_b, busy_c;
    logic        done_a, done_b, done_c;
    logic        error_a, error_b, error_c;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int sel = 0;
    int hi_cyc = 1;
    int lo_cyc = 1;
    logic ready_en = 1'b1;
    int rise_cyc[8];
    int lat_a, lat_c;

    logic [63:0] wd_a[$], wd_b[$], wd_c[$];
    logic [11:0] wa_a[$], wa_b[$], wa_c[$];
    logic [31:0] ra_a[$], ra_b[$], ra_c[$];
    logic rd_a_q = 1'b0, rd_b_q = 1'b0, rd_c_q = 1'b0;

    wire sel_rd = (sel == 0) ? rd_a : ((sel == 1) ? rd_b : rd_c);

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sd_sector_loader #(.BYTES_PER_WORD(4), .ADDR_W(12), .SECT_W(16), .TIMEOUT(1000)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .abort(abort),
        .start_sector(start_sector), .sector_count(sector_count),
        .sd_ready(sd_ready), .sd_byte_available(avail), .sd_dout(dout),
        .sd_rd(rd_a), .sd_address(addr_a), .wr_en(wr_en_a), .wr_addr(wr_addr_a),
        .wr_data(wr_data_a), .busy(busy_a), .done(done_a), .error(error_a));

    sd_sector_loader #(.BYTES_PER_WORD(1), .ADDR_W(12), .SECT_W(16), .TIMEOUT(1000)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .abort(abort),
        .start_sector(start_sector), .sector_count(sector_count),
        .sd_ready(sd_ready), .sd_byte_available(avail), .sd_dout(dout),
        .sd_rd(rd_b), .sd_address(addr_b), .wr_en(wr_en_b), .wr_addr(wr_addr_b),
        .wr_data(wr_data_b), .busy(busy_b), .done(done_b), .error(error_b));

    sd_sector_loader #(.BYTES_PER_WORD(8), .ADDR_W(4), .SECT_W(16), .TIMEOUT(1000)) dut_c (
        .clk(clk), .reset(reset), .start(start_c), .abort(abort),
        .start_sector(start_sector), .sector_count(sector_count),
        .sd_ready(sd_ready), .sd_byte_available(avail), .sd_dout(dout),
        .sd_rd(rd_c), .sd_address(addr_c), .wr_en(wr_en_c), .wr_addr(wr_addr_c),
        .wr_data(wr_data_c), .busy(busy_c), .done(done_c), .error(error_c));

    // SD controller model: accepts a read when idle, then sends bytes
    // 0x00..0xFF repeating (512 per sector) and returns to ready.
    initial begin
        sd_ready = 1'b1;
        avail    = 1'b0;
        dout     = 8'h00;
        forever begin
            @(negedge clk);
            if (!ready_en) begin
                sd_ready = 1'b0;
            end else if (sel_rd && sd_ready) begin
                sd_ready = 1'b0;
                @(negedge clk);
                for (int i = 0; i < 512; i++) begin
                    dout  = 8'(i);
                    avail = 1'b1;
                    if (i < 8) rise_cyc[i] = cyc;
                    repeat (hi_cyc) @(negedge clk);
                    avail = 1'b0;
                    repeat (lo_cyc) @(negedge clk);
                end
                sd_ready = 1'b1;
            end else begin
                sd_ready = 1'b1;
            end
        end
    end

    // Write / read-request monitors.
    always @(negedge clk) begin
        if (wr_en_a) begin
            if (wd_a.size() == 0) lat_a = cyc - rise_cyc[3];
            wd_a.push_back(64'(wr_data_a));
            wa_a.push_back(wr_addr_a);
        end
        if (wr_en_b) begin
            wd_b.push_back(64'(wr_data_b));
            wa_b.push_back(wr_addr_b);
        end
        if (wr_en_c) begin
            if (wd_c.size() == 0) lat_c = cyc - rise_cyc[7];
            wd_c.push_back(wr_data_c);
            wa_c.push_back(12'(wr_addr_c));
        end
        if (rd_a && !rd_a_q) ra_a.push_back(addr_a);
        if (rd_b && !rd_b_q) ra_b.push_back(addr_b);
        if (rd_c && !rd_c_q) ra_c.push_back(addr_c);
        rd_a_q = rd_a;
        rd_b_q = rd_b;
        rd_c_q = rd_c;
    end

    function automatic logic [63:0] exp_word(input int w, input int bpw);
        logic [63:0] v;
        v = '0;
        for (int b = 0; b < bpw; b++) v = (v << 8) | 64'((w * bpw + b) & 255);
        return v;
    endfunction

    task automatic clear_logs();
        wd_a.delete(); wa_a.delete(); ra_a.delete();
        wd_b.delete(); wa_b.delete(); ra_b.delete();
        wd_c.delete(); wa_c.delete(); ra_c.delete();
    endtask

    task automatic pulse_start(input int which, input logic [15:0] ss, input logic [15:0] sc);
        @(negedge clk);
        start_sector = ss;
        sector_count = sc;
        if (which == 0) start_a = 1'b1;
        else if (which == 1) start_b = 1'b1;
        else start_c = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        start_c = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({rd_a, addr_a, wr_en_a, wr_addr_a, wr_data_a, busy_a, done_a, error_a} !== '0) begin
            errors++;
            $display("FAIL reset_a_outputs: got rd=%0b addr=%0h wr_en=%0b wr_addr=%0h data=%0h busy=%0b done=%0b error=%0b, expected all 0",
                     rd_a, addr_a, wr_en_a, wr_addr_a, wr_data_a, busy_a, done_a, error_a);
        end
        checks++;
        if ({busy_b, done_b, error_b, busy_c, done_c, error_c, wr_addr_c, wr_data_c} !== '0) begin
            errors++;
            $display("FAIL reset_bc_outputs: got busy_b=%0b done_b=%0b busy_c=%0b done_c=%0b wr_addr_c=%0h, expected 0",
                     busy_b, done_b, busy_c, done_c, wr_addr_c);
        end
    endtask

    task automatic test_two_sectors();
        int n;
        sel = 0; hi_cyc = 1; lo_cyc = 1;
        clear_logs();
        pulse_start(0, 16'h0010, 16'd2);
        checks++;
        if (busy_a !== 1'b1) begin
            errors++;
            $display("FAIL two_sect_busy: got %0b expected 1", busy_a);
        end
        n = 0;
        while (busy_a && n < 6000) begin @(negedge clk); n++; end
        checks++;
        if (busy_a !== 1'b0) begin
            errors++;
            $display("FAIL two_sect_finish_timeout: busy got %0b expected 0", busy_a);
        end
        @(negedge clk);
        checks++;
        if (ra_a.size() != 2 || ra_a[0] !== 32'h2000 || ra_a[1] !== 32'h2200) begin
            errors++;
            $display("FAIL two_sect_sd_address: got %0d reads first=%0h last=%0h expected 2 reads 2000 2200",
                     ra_a.size(), (ra_a.size() > 0) ? ra_a[0] : 32'hx, (ra_a.size() > 1) ? ra_a[1] : 32'hx);
        end
        checks++;
        if (wd_a.size() != 256) begin
            errors++;
            $display("FAIL two_sect_word_count: got %0d expected 256", wd_a.size());
        end
        checks++;
        if (wd_a.size() > 0 && wd_a[0] !== 64'h00010203) begin
            errors++;
            $display("FAIL two_sect_word0: got %0h expected 00010203", wd_a[0]);
        end
        for (int i = 0; i < wd_a.size() && i < 256; i++) begin
            checks++;
            if (wd_a[i] !== exp_word(i, 4) || wa_a[i] !== 12'(i)) begin
                errors++;
                $display("FAIL two_sect_word[%0d]: got addr=%0h data=%0h expected addr=%0h data=%0h",
                         i, wa_a[i], wd_a[i], i, exp_word(i, 4));
            end
        end
        checks++;
        if (lat_a != 1) begin
            errors++;
            $display("FAIL two_sect_first_latency: got %0d cycles expected 1", lat_a);
        end
        checks++;
        if (done_a !== 1'b1 || error_a !== 1'b0 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL two_sect_status: got done=%0b error=%0b busy=%0b expected 1 0 0", done_a, error_a, busy_a);
        end
    endtask

    task automatic test_bpw1_slow();
        int n;
        sel = 1; hi_cyc = 3; lo_cyc = 1;
        clear_logs();
        pulse_start(1, 16'd5, 16'd1);
        n = 0;
        while (busy_b && n < 6000) begin @(negedge clk); n++; end
        checks++;
        if (busy_b !== 1'b0) begin
            errors++;
            $display("FAIL bpw1_finish_timeout: busy got %0b expected 0", busy_b);
        end
        @(negedge clk);
        checks++;
        if (wd_b.size() != 512) begin
            errors++;
            $display("FAIL bpw1_write_count: got %0d expected 512", wd_b.size());
        end
        checks++;
        if (ra_b.size() != 1 || ra_b[0] !== 32'h0A00) begin
            errors++;
            $display("FAIL bpw1_sd_address: got %0d reads first=%0h expected 1 read a00",
                     ra_b.size(), (ra_b.size() > 0) ? ra_b[0] : 32'hx);
        end
        for (int i = 0; i < wd_b.size() && i < 512; i++) begin
            checks++;
            if (wd_b[i] !== 64'(i & 255) || wa_b[i] !== 12'(i)) begin
                errors++;
                $display("FAIL bpw1_byte[%0d]: got addr=%0h data=%0h expected addr=%0h data=%0h",
                         i, wa_b[i], wd_b[i], i, i & 255);
            end
        end
        checks++;
        if (done_b !== 1'b1 || error_b !== 1'b0) begin
            errors++;
            $display("FAIL bpw1_status: got done=%0b error=%0b expected 1 0", done_b, error_b);
        end
        hi_cyc = 1;
    endtask

    task automatic test_timeout();
        int n;
        sel = 0;
        ready_en = 1'b0;
        repeat (2) @(negedge clk);
        clear_logs();
        pulse_start(0, 16'd0, 16'd1);
        n = 0;
        while (busy_a && n < 3000) begin n++; @(negedge clk); end
        checks++;
        if (n != 1000) begin
            errors++;
            $display("FAIL timeout_cycles: got %0d busy cycles expected 1000", n);
        end
        checks++;
        if (error_a !== 1'b1 || done_a !== 1'b0 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL timeout_status: got error=%0b done=%0b busy=%0b expected 1 0 0", error_a, done_a, busy_a);
        end
        checks++;
        if (ra_a.size() != 0) begin
            errors++;
            $display("FAIL timeout_no_rd: got %0d read requests expected 0", ra_a.size());
        end
        ready_en = 1'b1;
        repeat (2) @(negedge clk);
        pulse_start(0, 16'd7, 16'd1);
        checks++;
        if (error_a !== 1'b0 || busy_a !== 1'b1) begin
            errors++;
            $display("FAIL timeout_error_cleared: got error=%0b busy=%0b expected 0 1", error_a, busy_a);
        end
        n = 0;
        while (busy_a && n < 4000) begin @(negedge clk); n++; end
        @(negedge clk);
        checks++;
        if (done_a !== 1'b1 || wd_a.size() != 128) begin
            errors++;
            $display("FAIL timeout_reload: got done=%0b words=%0d expected 1 128", done_a, wd_a.size());
        end
    endtask

    task automatic test_abort();
        int n;
        sel = 0;
        clear_logs();
        pulse_start(0, 16'd0, 16'd2);
        n = 0;
        while (wd_a.size() < 25 && n < 3000) begin @(negedge clk); n++; end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (busy_a !== 1'b1 || rd_a !== 1'b0) begin
            errors++;
            $display("FAIL abort_drain: got busy=%0b sd_rd=%0b expected 1 0", busy_a, rd_a);
        end
        n = 0;
        while (busy_a && n < 3000) begin @(negedge clk); n++; end
        checks++;
        if (busy_a !== 1'b0 || sd_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_leave_drain: got busy=%0b sd_ready=%0b expected 0 1", busy_a, sd_ready);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (wd_a.size() != 25) begin
            errors++;
            $display("FAIL abort_no_more_writes: got %0d words expected 25", wd_a.size());
        end
        checks++;
        if (done_a !== 1'b0 || error_a !== 1'b0 || ra_a.size() != 1) begin
            errors++;
            $display("FAIL abort_status: got done=%0b error=%0b reads=%0d expected 0 0 1", done_a, error_a, ra_a.size());
        end
    endtask

    task automatic test_zero_count();
        int busy_seen;
        int reads;
        reads = ra_a.size();
        checks++;
        if (done_a !== 1'b0) begin
            errors++;
            $display("FAIL zero_pre_done: got %0b expected 0", done_a);
        end
        pulse_start(0, 16'd9, 16'd0);
        checks++;
        if (done_a !== 1'b1 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL zero_done_next_cycle: got done=%0b busy=%0b expected 1 0", done_a, busy_a);
        end
        busy_seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (busy_a) busy_seen++;
            @(negedge clk);
        end
        checks++;
        if (busy_seen != 0 || ra_a.size() != reads) begin
            errors++;
            $display("FAIL zero_no_activity: got busy cycles=%0d new reads=%0d expected 0 0", busy_seen, ra_a.size() - reads);
        end
    endtask

    task automatic test_restart_after_abort();
        int n;
        sel = 0;
        clear_logs();
        pulse_start(0, 16'd3, 16'd1);
        n = 0;
        while (busy_a && n < 4000) begin @(negedge clk); n++; end
        @(negedge clk);
        checks++;
        if (wd_a.size() != 128 || ra_a.size() != 1) begin
            errors++;
            $display("FAIL restart_counts: got words=%0d reads=%0d expected 128 1", wd_a.size(), ra_a.size());
        end else begin
            checks++;
            if (ra_a[0] !== 32'h600 || wa_a[0] !== 12'd0 || wa_a[127] !== 12'd127 ||
                wd_a[0] !== 64'h00010203 || wd_a[127] !== 64'hFCFDFEFF) begin
                errors++;
                $display("FAIL restart_content: got addr=%0h wa0=%0h wa127=%0h w0=%0h w127=%0h expected 600 0 7f 00010203 fcfdfeff",
                         ra_a[0], wa_a[0], wa_a[127], wd_a[0], wd_a[127]);
            end
        end
        checks++;
        if (done_a !== 1'b1 || error_a !== 1'b0) begin
            errors++;
            $display("FAIL restart_status: got done=%0b error=%0b expected 1 0", done_a, error_a);
        end
    endtask

    task automatic test_wrap();
        int n;
        int wraps;
        sel = 2;
        clear_logs();
        pulse_start(2, 16'd1, 16'd1);
        n = 0;
        while (busy_c && n < 4000) begin @(negedge clk); n++; end
        repeat (2) @(negedge clk);
        checks++;
        if (wd_c.size() != 64) begin
            errors++;
            $display("FAIL wrap_write_count: got %0d expected 64", wd_c.size());
        end
        wraps = 0;
        for (int i = 0; i < wd_c.size() && i < 64; i++) begin
            if (i > 0 && wa_c[i-1] == 12'd15 && wa_c[i] == 12'd0) wraps++;
            checks++;
            if (wd_c[i] !== exp_word(i, 8) || wa_c[i] !== 12'(i % 16)) begin
                errors++;
                $display("FAIL wrap_word[%0d]: got addr=%0h data=%0h expected addr=%0h data=%0h",
                         i, wa_c[i], wd_c[i], i % 16, exp_word(i, 8));
            end
        end
        if (wr_addr_c == 4'd0) wraps++;
        checks++;
        if (wraps != 4) begin
            errors++;
            $display("FAIL wrap_count: got %0d wraps expected 4", wraps);
        end
        checks++;
        if (lat_c != 1 || done_c !== 1'b1 || ra_c.size() != 1 || ra_c[0] !== 32'h200) begin
            errors++;
            $display("FAIL wrap_status: got latency=%0d done=%0b reads=%0d expected 1 1 1 (addr 200)",
                     lat_c, done_c, ra_c.size());
        end
    endtask

    task automatic test_reset_mid();
        int n;
        sel = 2;
        clear_logs();
        pulse_start(2, 16'd2, 16'd1);
        n = 0;
        while (wd_c.size() < 10 && n < 3000) begin @(negedge clk); n++; end
        checks++;
        if (busy_c !== 1'b1 || wr_addr_c === 4'd0) begin
            errors++;
            $display("FAIL reset_mid_precondition: got busy=%0b wr_addr=%0h expected 1 nonzero", busy_c, wr_addr_c);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({rd_c, addr_c, wr_en_c, wr_addr_c, wr_data_c, busy_c, done_c, error_c} !== '0) begin
            errors++;
            $display("FAIL reset_mid_async: got rd=%0b addr=%0h wr_en=%0b wr_addr=%0h data=%0h busy=%0b done=%0b error=%0b, expected all 0",
                     rd_c, addr_c, wr_en_c, wr_addr_c, wr_data_c, busy_c, done_c, error_c);
        end
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        while (!sd_ready && n < 3000) begin @(negedge clk); n++; end
        repeat (2) @(negedge clk);
        checks++;
        if (busy_c !== 1'b0 || done_c !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_after: got busy=%0b done=%0b expected 0 0", busy_c, done_c);
        end
    endtask

    initial begin
        reset = 1'b1;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        abort = 1'b0;
        start_sector = '0;
        sector_count = '0;
        test_reset();
        test_two_sectors();
        test_bpw1_slow();
        test_timeout();
        test_abort();
        test_zero_count();
        test_restart_after_abort();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
